// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard responder: forwarding, stall/flush, memory freeze, perf counters
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             MemtoRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemBusyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    logic [3:0] ra1_e_q, ra2_e_q, wa3_e_q, wa3_m_q, wa3_w_q;
    logic [3:0] ra1_e_d, ra2_e_d, wa3_e_d, wa3_m_d, wa3_w_d;
    logic       ld_stall;
    logic [1:0] fwd_a, fwd_b;

    // Memory stage result is younger than writeback, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic [3:0] wm,
                                           input logic [3:0] ww, input logic rwm,
                                           input logic rww);
        if (rwm && (ra == wm))
            return 2'b10;
        else if (rww && (ra == ww))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ld_stall = MemtoRegE && ((RA1D == wa3_e_q) || (RA2D == wa3_e_q));
    assign fwd_a    = fwd_sel(ra1_e_q, wa3_m_q, wa3_w_q, RegWriteM, RegWriteW);
    assign fwd_b    = fwd_sel(ra2_e_q, wa3_m_q, wa3_w_q, RegWriteM, RegWriteW);

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        if (reset) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (MemBusyM) begin
                // Freeze: pending flushes are re-evaluated once memory is ready.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = ld_stall || PCWrPendingF;
                StallD = ld_stall;
                FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
                FlushE = ld_stall || BranchTakenE;
                FlushW = 1'b0;
            end
        end
    end

    always_comb begin
        ra1_e_d = ra1_e_q;
        ra2_e_d = ra2_e_q;
        wa3_e_d = wa3_e_q;
        wa3_m_d = wa3_m_q;
        wa3_w_d = wa3_w_q;
        if (!MemBusyM) begin
            wa3_w_d = wa3_m_q;
            wa3_m_d = wa3_e_q;
            if (FlushE) begin
                ra1_e_d = 4'd0;
                ra2_e_d = 4'd0;
                wa3_e_d = 4'd0;
            end else begin
                ra1_e_d = RA1D;
                ra2_e_d = RA2D;
                wa3_e_d = WA3D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ra1_e_q <= 4'd0;
            ra2_e_q <= 4'd0;
            wa3_e_q <= 4'd0;
            wa3_m_q <= 4'd0;
            wa3_w_q <= 4'd0;
        end else begin
            ra1_e_q <= ra1_e_d;
            ra2_e_q <= ra2_e_d;
            wa3_e_q <= wa3_e_d;
            wa3_m_q <= wa3_m_d;
            wa3_w_q <= wa3_w_d;
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (StallF),
        .count_o (StallCount)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (FlushE),
        .count_o (FlushCount)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed table, random model comparison and counter saturation for hazard_unit
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, WA3D;
    logic       MemtoRegE, RegWriteM, RegWriteW, PCWrPendingF, PCSrcW, BranchTakenE, MemBusyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [15:0] StallCount, FlushCount;

    logic       s_reset, s_busy;
    logic [1:0] s_fa, s_fb;
    logic       s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw;
    logic [3:0] s_sc, s_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .MemBusyM(MemBusyM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(s_reset), .RA1D(4'd0), .RA2D(4'd0), .WA3D(4'd0),
        .MemtoRegE(1'b0), .RegWriteM(1'b0), .RegWriteW(1'b0),
        .PCWrPendingF(1'b0), .PCSrcW(1'b0), .BranchTakenE(1'b0),
        .MemBusyM(s_busy), .ForwardAE(s_fa), .ForwardBE(s_fb),
        .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .StallM(s_sm),
        .FlushD(s_fd), .FlushE(s_fe), .FlushW(s_fw),
        .StallCount(s_sc), .FlushCount(s_fc)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] ra1, ra2, wa3;
        logic       mtr, rwm, rww, pcp, pcs, bte, busy;
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe, fw;
        logic [15:0] sc, fc;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a three-slot pipeline of {ra1, ra2, wa3} instruction tags.
    logic [3:0] p_ra1[3], p_ra2[3], p_wa3[3];
    int m_sc, m_fc;
    logic [1:0] m_fa, m_fb;
    logic m_sf, m_sd, m_se, m_fd, m_fe, m_fw;

    function automatic vec_t mk(logic rst_n, int ra1, int ra2, int wa3,
                                logic mtr, logic rwm, logic rww, logic pcp, logic pcs,
                                logic bte, logic busy, int fa, int fb, logic sf, logic sd,
                                logic se, logic fd, logic fe, logic fw, int sc, int fc);
        vec_t v;
        v.rst_n = rst_n; v.ra1 = 4'(ra1); v.ra2 = 4'(ra2); v.wa3 = 4'(wa3);
        v.mtr = mtr; v.rwm = rwm; v.rww = rww; v.pcp = pcp; v.pcs = pcs;
        v.bte = bte; v.busy = busy; v.fa = 2'(fa); v.fb = 2'(fb);
        v.sf = sf; v.sd = sd; v.se = se; v.fd = fd; v.fe = fe; v.fw = fw;
        v.sc = 16'(sc); v.fc = 16'(fc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst_n; RA1D = v.ra1; RA2D = v.ra2; WA3D = v.wa3;
        MemtoRegE = v.mtr; RegWriteM = v.rwm; RegWriteW = v.rww;
        PCWrPendingF = v.pcp; PCSrcW = v.pcs; BranchTakenE = v.bte; MemBusyM = v.busy;
    endtask

    function automatic logic [1:0] ref_fwd(logic [3:0] ra);
        if (RegWriteM && ra == p_wa3[1]) return 2'b10;
        if (RegWriteW && ra == p_wa3[2]) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        logic ld;
        ld = MemtoRegE && (RA1D == p_wa3[0] || RA2D == p_wa3[0]);
        if (!reset) begin
            {m_fa, m_fb} = 4'b0;
            {m_sf, m_sd, m_se} = 3'b000;
            {m_fd, m_fe, m_fw} = 3'b111;
        end else if (MemBusyM) begin
            m_fa = ref_fwd(p_ra1[0]); m_fb = ref_fwd(p_ra2[0]);
            {m_sf, m_sd, m_se} = 3'b111;
            {m_fd, m_fe, m_fw} = 3'b001;
        end else begin
            m_fa = ref_fwd(p_ra1[0]); m_fb = ref_fwd(p_ra2[0]);
            m_sf = ld | PCWrPendingF; m_sd = ld; m_se = 1'b0;
            m_fd = PCWrPendingF | PCSrcW | BranchTakenE;
            m_fe = ld | BranchTakenE; m_fw = 1'b0;
        end
    endtask

    task automatic model_clock();
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin p_ra1[i] = 0; p_ra2[i] = 0; p_wa3[i] = 0; end
            m_sc = 0; m_fc = 0;
        end else begin
            if (m_sf && m_sc < 65535) m_sc++;
            if (m_fe && m_fc < 65535) m_fc++;
            if (!MemBusyM) begin
                for (int i = 2; i > 0; i--) begin
                    p_ra1[i] = p_ra1[i-1]; p_ra2[i] = p_ra2[i-1]; p_wa3[i] = p_wa3[i-1];
                end
                if (m_fe) begin p_ra1[0] = 0; p_ra2[0] = 0; p_wa3[0] = 0; end
                else begin p_ra1[0] = RA1D; p_ra2[0] = RA2D; p_wa3[0] = WA3D; end
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        //         rst ra1 ra2 wa3 mtr rwm rww pcp pcs bte bsy  fa fb sf sd se fd fe fw  sc fc
        vecs.push_back(mk(0, 3, 5, 7, 1, 1, 1, 1, 0, 1, 1,  0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 9, 2, 4, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1,  2, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 1, 0, 0, 1, 1, 0, 2, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 3, 2));
        vecs.push_back(mk(1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3, 2));
        vecs.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3, 2));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 9, 9, 9, 0, 1, 0, 0, 0, 1, 1, 2, 0, 1, 1, 1, 0, 0, 1, 3 + k, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0,  2, 0, 0, 0, 0, 1, 1, 0, 6, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 6, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 1, 6, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 1, 1, 0, 0, 0));

        s_reset = 1'b0; s_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin p_ra1[i] = 0; p_ra2[i] = 0; p_wa3[i] = 0; end
        m_sc = 0; m_fc = 0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v);
            #2;
            chk($sformatf("v%0d ForwardAE", i), 16'(ForwardAE), 16'(v.fa));
            chk($sformatf("v%0d ForwardBE", i), 16'(ForwardBE), 16'(v.fb));
            chk($sformatf("v%0d StallF", i), 16'(StallF), 16'(v.sf));
            chk($sformatf("v%0d StallD", i), 16'(StallD), 16'(v.sd));
            chk($sformatf("v%0d StallE/M", i), 16'({StallE, StallM}), 16'({v.se, v.se}));
            chk($sformatf("v%0d FlushD", i), 16'(FlushD), 16'(v.fd));
            chk($sformatf("v%0d FlushE", i), 16'(FlushE), 16'(v.fe));
            chk($sformatf("v%0d FlushW", i), 16'(FlushW), 16'(v.fw));
            chk($sformatf("v%0d StallCount", i), StallCount, v.sc);
            chk($sformatf("v%0d FlushCount", i), FlushCount, v.fc);
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 31) != 0);
            RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
            WA3D = 4'($urandom_range(0, 3));
            MemtoRegE = ($urandom_range(0, 3) == 0); RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom); PCWrPendingF = ($urandom_range(0, 5) == 0);
            PCSrcW = ($urandom_range(0, 7) == 0); BranchTakenE = ($urandom_range(0, 5) == 0);
            MemBusyM = ($urandom_range(0, 4) == 0);
            #2;
            model_eval();
            chk("rnd ForwardAE", 16'(ForwardAE), 16'(m_fa));
            chk("rnd ForwardBE", 16'(ForwardBE), 16'(m_fb));
            chk("rnd stalls", 16'({StallF, StallD, StallE, StallM}), 16'({m_sf, m_sd, m_se, m_se}));
            chk("rnd flushes", 16'({FlushD, FlushE, FlushW}), 16'({m_fd, m_fe, m_fw}));
            chk("rnd StallCount", StallCount, 16'(m_sc));
            chk("rnd FlushCount", FlushCount, 16'(m_fc));
            tick();
        end

        s_reset = 1'b1; s_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #2;
            chk($sformatf("sat cycle %0d StallCount", k), 16'(s_sc), 16'((k < 15) ? k : 15));
            chk($sformatf("sat cycle %0d StallF", k), 16'(s_sf), 16'd1);
            @(posedge clk); #1;
        end
        #2;
        chk("sat final StallCount", 16'(s_sc), 16'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard responder for the 5-stage pipelined ARM core. It is the consumer of the controller's hazard-side outputs (PCWrPendingF, RegWriteM, MemtoRegE, BranchTakenE) and the producer of the controller's FlushE input.
- Tracks source/destination register numbers through E/M/W internally, generates forwarding selects, stall/flush controls and a data-memory wait-state freeze.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- RA1D  in  4  Rn field of instruction in Decode
- RA2D  in  4  second read address in Decode (Rm or Rd, post RegSrc mux)
- WA3D  in  4  destination register in Decode
- MemtoRegE  in  1  load in Execute (from controller)
- RegWriteM  in  1  condition-qualified register write in Memory (from controller)
- RegWriteW  in  1  register write in Writeback (from controller)
- PCWrPendingF  in  1  PC write in flight in D/E/M (from controller)
- PCSrcW  in  1  PC write in Writeback
- BranchTakenE  in  1  branch resolved taken in Execute
- MemBusyM  in  1  data memory not ready this cycle
- ForwardAE  out  2  SrcA select: 00 RF, 01 ResultW, 10 ALUOutM
- ForwardBE  out  2  SrcB select, same encoding
- StallF, StallD, StallE, StallM  out  1 each  hold stage register
- FlushD, FlushE, FlushW  out  1 each  clear stage register to bubble
- StallCount  out  CNT_W  cycles with StallF=1
- FlushCount  out  CNT_W  cycles with FlushE=1

Behaviour:
- State: RA1E, RA2E, WA3E, WA3M, WA3W (4 bits each), StallCount, FlushCount. All hazard/forward outputs are combinational from state and current inputs, with zero-cycle latency.
- Reset (reset=0 at edge): all state registers load 0.
- While reset=0: FlushD=FlushE=FlushW=1, all Stall*=0, Forward*=00, counters hold 0.
- LdStall = MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)).
- Forwarding, A side:
  - 10 if RegWriteM & RA1E==WA3M.
  - Else 01 if RegWriteW & RA1E==WA3W.
  - Else 00.
  - M has priority over W when both match.
  - B side is identical using RA2E.
- Normal mode (MemBusyM=0):
  - StallF = LdStall | PCWrPendingF
  - StallD = LdStall
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
  - FlushE = LdStall | BranchTakenE
  - StallE = StallM = FlushW = 0
- Freeze mode (MemBusyM=1), which overrides normal mode:
  - StallF = StallD = StallE = StallM = 1, FlushW = 1.
  - FlushD = FlushE = 0; a taken branch or load-use is re-evaluated when MemBusyM drops.
  - Forward selects still computed.
- Tracking update at each edge with reset=1:
  - MemBusyM=1: all tracking registers hold.
  - Else: WA3W<=WA3M; WA3M<=WA3E.
  - Then if FlushE: RA1E, RA2E, WA3E <= 0. Otherwise they load RA1D, RA2D, WA3D.
- Counters:
  - StallCount increments by 1 each non-reset cycle with StallF=1, including freeze cycles.
  - FlushCount increments each non-reset cycle with FlushE=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Simultaneous LdStall and BranchTakenE: FlushE=1, StallD=1, FlushD=1. Flush wins for D, and StallF stays 1.
- Reset asserted mid-freeze: reset wins, and state clears on that edge.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> FlushD/E/W=1, stalls 0, Forward*=00, StallCount=FlushCount=0; after release with idle inputs, all flush/stall outputs=0.
- Forwarding priority: WA3D=3 issued twice consecutively, then RA1D=3, with RegWriteM=RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> ForwardAE=01. With RA2D=4 -> ForwardBE=00.
- Load-use: WA3E=5, MemtoRegE=1, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle; next cycle WA3E=0; StallCount=1, FlushCount=1.
- Branch: BranchTakenE=1, PCWrPendingF=1 for one cycle -> FlushD=FlushE=1, StallF=1. PCSrcW=1 alone -> FlushD=1 only.
- Freeze: MemBusyM=1 for 3 cycles while BranchTakenE=1 -> StallF/D/E/M=1, FlushW=1, FlushE=0, and WA3E/M/W unchanged. On the cycle MemBusyM drops, FlushE=1. StallCount advances by 3.
- Saturation: CNT_W=4, force StallF=1 for 20 cycles -> StallCount reaches 15 and holds.
